// File: rtl/ann_pkg.sv
// Shared definitions for the ANN temperature predictor.
//   W, N_IN, N_HID, N_WT, LR_SHIFT : network geometry and arithmetic width
//   word_t                         : W-bit signed datapath word
//   state_t                        : controller states
//   hid_idx / out_idx              : weight register file address helpers
package ann_pkg;

  localparam int unsigned W        = 156;
  localparam int unsigned N_IN     = 4;
  localparam int unsigned N_HID    = 8;
  localparam int unsigned N_WT     = N_IN * N_HID + N_HID;
  localparam int unsigned LR_SHIFT = 10;
  localparam int unsigned IDX_W    = $clog2(N_WT);

  typedef logic signed [W-1:0] word_t;

  // Fixed-point scale: weights and activations are in milli-units
  localparam word_t MILLI = word_t'(1000);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HID,
    ST_OUT,
    ST_ERR,
    ST_UPD
  } state_t;

  // Hidden weight w[n][i] lives at n*N_IN+i
  function automatic logic [IDX_W-1:0] hid_idx(input int unsigned n, input int unsigned i);
    return IDX_W'(n * N_IN + i);
  endfunction

  // Output weight v[n] lives after all hidden weights
  function automatic logic [IDX_W-1:0] out_idx(input int unsigned n);
    return IDX_W'(N_IN * N_HID + n);
  endfunction

endpackage

// File: rtl/ann_hidden_neuron.sv
// One hidden neuron: 4-way signed multiply-accumulate followed by ReLU.
// Purely combinational; the parent registers the result.
//   w_row : weights w[n][0..N_IN-1] (milli-units)
//   t_in  : latched temperatures T0..T(N_IN-1)
//   h_out : max(0, sum w*T), wrapped to W bits
module ann_hidden_neuron
  import ann_pkg::*;
(
  input  logic signed [W-1:0] w_row [N_IN],
  input  logic signed [W-1:0] t_in  [N_IN],
  output logic signed [W-1:0] h_out
);

  word_t acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      acc = acc + w_row[i] * t_in[i];
    end
    h_out = acc[W-1] ? '0 : acc;
  end

endmodule

// File: rtl/ann_temp_predictor.sv
// 4-8-1 ReLU network predicting the next daily maximum temperature.
// Holds 40 weights (serial load/readback), predicts on a request edge and
// trains by one step of online gradient descent on request.
//   Clk, Reset_l            : clock, asynchronous active-low reset
//   Temperature_in_0..3     : inputs T0..T3
//   Weight_in               : serial weight word (Weight_Save_enable strobe)
//   Target                  : training target
//   training_enable_h       : train request (level, sampled in IDLE)
//   tb_rev_ready_h          : predict request (rising edge)
//   Weight_Save_enable      : write one weight per edge
//   Weight_Load_enable      : read one weight per edge onto New_weight_out
//   Data_out                : prediction y (milli-units)
//   New_weight_out          : readback weight word
//   Ready_Signal            : one-cycle pulse when predict/train completes
module ann_temp_predictor
  import ann_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_l,
  input  logic signed [W-1:0] Temperature_in_0,
  input  logic signed [W-1:0] Temperature_in_1,
  input  logic signed [W-1:0] Temperature_in_2,
  input  logic signed [W-1:0] Temperature_in_3,
  input  logic signed [W-1:0] Weight_in,
  input  logic signed [W-1:0] Target,
  input  logic                training_enable_h,
  input  logic                tb_rev_ready_h,
  input  logic                Weight_Save_enable,
  input  logic                Weight_Load_enable,
  output logic signed [W-1:0] Data_out,
  output logic signed [W-1:0] New_weight_out,
  output logic                Ready_Signal
);

  state_t           state, state_nxt;
  word_t            wt     [N_WT];
  word_t            wt_nxt [N_WT];
  word_t            w_mat  [N_HID][N_IN];
  word_t            t_q    [N_IN];
  word_t            h_q    [N_HID];
  word_t            h_c    [N_HID];
  word_t            e_q;
  word_t            y_acc, y_c, grad;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             rev_prev, rev_rise;
  logic             save_wr, latch_t;

  assign rev_rise = tb_rev_ready_h & ~rev_prev;

  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Save outranks train, train outranks predict; requests outside IDLE are dropped
  always_comb begin
    state_nxt = state;
    save_wr   = 1'b0;
    latch_t   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Weight_Save_enable) begin
          save_wr = 1'b1;
        end else if (training_enable_h) begin
          state_nxt = ST_ERR;
        end else if (rev_rise) begin
          latch_t   = 1'b1;
          state_nxt = ST_HID;
        end
      end
      ST_HID:  state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_UPD;
      ST_UPD:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned n = 0; n < N_HID; n++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        w_mat[n][i] = wt[hid_idx(n, i)];
      end
    end
  end

  for (genvar n = 0; n < N_HID; n++) begin : g_hid
    ann_hidden_neuron u_neuron (
      .w_row (w_mat[n]),
      .t_in  (t_q),
      .h_out (h_c[n])
    );
  end

  always_comb begin
    y_acc = '0;
    for (int unsigned n = 0; n < N_HID; n++) begin
      y_acc = y_acc + wt[out_idx(n)] * h_q[n];
    end
    y_c = y_acc / MILLI;
  end

  // Gradient step; every term reads the pre-update v[n]
  always_comb begin
    grad = '0;
    for (int unsigned k = 0; k < N_WT; k++) wt_nxt[k] = wt[k];
    for (int unsigned n = 0; n < N_HID; n++) begin
      grad = (e_q * wt[out_idx(n)]) / MILLI;
      wt_nxt[out_idx(n)] = wt[out_idx(n)] + (((e_q * h_q[n]) / MILLI) >>> LR_SHIFT);
      if (h_q[n] != '0) begin
        for (int unsigned i = 0; i < N_IN; i++) begin
          wt_nxt[hid_idx(n, i)] = wt[hid_idx(n, i)] + ((grad * t_q[i]) >>> LR_SHIFT);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      for (int unsigned k = 0; k < N_WT; k++) wt[k] <= '0;
      for (int unsigned i = 0; i < N_IN; i++)  t_q[i] <= '0;
      for (int unsigned n = 0; n < N_HID; n++) h_q[n] <= '0;
      e_q            <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      rev_prev       <= 1'b0;
      Data_out       <= '0;
      New_weight_out <= '0;
      Ready_Signal   <= 1'b0;
    end else begin
      rev_prev     <= tb_rev_ready_h;
      Ready_Signal <= (state == ST_OUT) || (state == ST_UPD);

      if (!Weight_Save_enable) begin
        wr_idx <= '0;
      end else if (save_wr) begin
        wt[wr_idx] <= Weight_in;
        wr_idx     <= (wr_idx == IDX_W'(N_WT - 1)) ? '0 : wr_idx + 1'b1;
      end

      if (Weight_Load_enable) begin
        New_weight_out <= wt[rd_idx];
        rd_idx         <= (rd_idx == IDX_W'(N_WT - 1)) ? '0 : rd_idx + 1'b1;
      end else begin
        rd_idx <= '0;
      end

      if (latch_t) begin
        t_q[0] <= Temperature_in_0;
        t_q[1] <= Temperature_in_1;
        t_q[2] <= Temperature_in_2;
        t_q[3] <= Temperature_in_3;
      end

      if (state == ST_HID) begin
        for (int unsigned n = 0; n < N_HID; n++) h_q[n] <= h_c[n];
      end

      if (state == ST_OUT) Data_out <= y_c;

      if (state == ST_ERR) e_q <= Target * MILLI - Data_out;

      if (state == ST_UPD) begin
        for (int unsigned k = 0; k < N_WT; k++) wt[k] <= wt_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_ann_temp_predictor.sv
module tb_ann_temp_predictor;
  import ann_pkg::*;

  localparam word_t K = word_t'(1000);

  logic  Clk = 1'b0;
  logic  Reset_l = 1'b0;
  word_t Temperature_in_0 = '0, Temperature_in_1 = '0;
  word_t Temperature_in_2 = '0, Temperature_in_3 = '0;
  word_t Weight_in = '0, Target = '0;
  logic  training_enable_h = 1'b0, tb_rev_ready_h = 1'b0;
  logic  Weight_Save_enable = 1'b0, Weight_Load_enable = 1'b0;
  word_t Data_out, New_weight_out;
  logic  Ready_Signal;

  ann_temp_predictor dut (
    .Clk                (Clk),
    .Reset_l            (Reset_l),
    .Temperature_in_0   (Temperature_in_0),
    .Temperature_in_1   (Temperature_in_1),
    .Temperature_in_2   (Temperature_in_2),
    .Temperature_in_3   (Temperature_in_3),
    .Weight_in          (Weight_in),
    .Target             (Target),
    .training_enable_h  (training_enable_h),
    .tb_rev_ready_h     (tb_rev_ready_h),
    .Weight_Save_enable (Weight_Save_enable),
    .Weight_Load_enable (Weight_Load_enable),
    .Data_out           (Data_out),
    .New_weight_out     (New_weight_out),
    .Ready_Signal       (Ready_Signal)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference state: flat weight list, last inputs, hidden activations, prediction
  word_t mw [N_WT];
  word_t mT [N_IN];
  word_t mh [N_HID];
  word_t my;

  typedef struct {
    int     w;
    int     v;
    int     t0, t1, t2, t3;
    longint y;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N_WT; k++) mw[k] = '0;
    for (int i = 0; i < N_IN; i++) mT[i] = '0;
    for (int n = 0; n < N_HID; n++) mh[n] = '0;
    my = '0;
  endfunction

  function automatic void model_predict();
    word_t s;
    for (int n = 0; n < N_HID; n++) begin
      s = '0;
      for (int i = 0; i < N_IN; i++) s = s + mw[n*4 + i] * mT[i];
      mh[n] = (s < 0) ? '0 : s;
    end
    s = '0;
    for (int n = 0; n < N_HID; n++) s = s + mw[32 + n] * mh[n];
    my = s / K;
  endfunction

  function automatic void model_train(input int target);
    word_t e, g;
    word_t nw [N_WT];
    e = word_t'(target) * K - my;
    nw = mw;
    for (int n = 0; n < N_HID; n++) begin
      nw[32 + n] = mw[32 + n] + (((e * mh[n]) / K) >>> 10);
      if (mh[n] > 0) begin
        g = (e * mw[32 + n]) / K;
        for (int i = 0; i < N_IN; i++) nw[n*4 + i] = mw[n*4 + i] + ((g * mT[i]) >>> 10);
      end
    end
    mw = nw;
  endfunction

  function automatic void set_uniform(input int w, input int v);
    for (int k = 0; k < 32; k++) mw[k] = word_t'(w);
    for (int k = 32; k < N_WT; k++) mw[k] = word_t'(v);
  endfunction

  task automatic do_reset();
    Reset_l = 1'b0;
    tick();
    tick();
    Reset_l = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic save_words();
    Weight_Save_enable = 1'b1;
    for (int k = 0; k < N_WT; k++) begin
      Weight_in = mw[k];
      tick();
    end
    Weight_Save_enable = 1'b0;
    tick();
  endtask

  task automatic readback(input string name);
    Weight_Load_enable = 1'b1;
    for (int k = 0; k < N_WT; k++) begin
      tick();
      chk(name, New_weight_out, mw[k]);
    end
    Weight_Load_enable = 1'b0;
    tick();
  endtask

  // Counts edges from the request edge (edge 1) to the Ready pulse
  task automatic wait_ready(input string name);
    int lat;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tb_rev_ready_h    = 1'b0;
      training_enable_h = 1'b0;
      if (Ready_Signal) begin
        lat = c;
        break;
      end
    end
    chk(name, word_t'(lat), word_t'(3));
    tick();
    chk({name, "_pulse_end"}, word_t'(Ready_Signal), '0);
  endtask

  task automatic predict(input int t0, input int t1, input int t2, input int t3);
    Temperature_in_0 = word_t'(t0);
    Temperature_in_1 = word_t'(t1);
    Temperature_in_2 = word_t'(t2);
    Temperature_in_3 = word_t'(t3);
    mT[0] = word_t'(t0);
    mT[1] = word_t'(t1);
    mT[2] = word_t'(t2);
    mT[3] = word_t'(t3);
    tb_rev_ready_h = 1'b1;
    wait_ready("pred_latency");
    model_predict();
  endtask

  task automatic train(input int target);
    Target = word_t'(target);
    training_enable_h = 1'b1;
    wait_ready("train_latency");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    word_t y_before;

    tbl[0] = '{1000, 1000, 10, 20, 30, 40, 800000};
    tbl[1] = '{-1000, 1000, 10, 20, 30, 40, 0};
    tbl[2] = '{500, -2000, 1, 2, 3, 4, -80000};
    tbl[3] = '{2, 3, 1, 1, 1, 0, 0};
    tbl[4] = '{7, -3, 100, 0, 0, 0, -16};
    tbl[5] = '{1000, 1000, -10, 5, 0, 0, 0};

    // Reset state
    do_reset();
    chk("rst_data_out", Data_out, '0);
    chk("rst_weight_out", New_weight_out, '0);
    chk("rst_ready", word_t'(Ready_Signal), '0);
    readback("rst_weights");

    // Table-driven predictions with uniform weights
    foreach (tbl[k]) begin
      set_uniform(tbl[k].w, tbl[k].v);
      save_words();
      predict(tbl[k].t0, tbl[k].t1, tbl[k].t2, tbl[k].t3);
      chk($sformatf("tbl%0d_y", k), Data_out, word_t'(tbl[k].y));
    end

    // Sequential save 1..40, readback with wrap on the 41st word
    for (int k = 0; k < N_WT; k++) mw[k] = word_t'(k + 1);
    save_words();
    Weight_Load_enable = 1'b1;
    for (int k = 0; k <= N_WT; k++) begin
      tick();
      chk("seq_readback", New_weight_out, mw[k % N_WT]);
    end
    Weight_Load_enable = 1'b0;
    tick();

    // Zero-error training leaves weights untouched
    set_uniform(1000, 1000);
    save_words();
    predict(10, 20, 30, 40);
    chk("zero_err_y", Data_out, word_t'(800000));
    train(800);
    chk("zero_err_dout_hold", Data_out, word_t'(800000));
    readback("zero_err_weights");

    // Single active path, hand-computed update
    model_reset();
    mw[0]  = word_t'(1000);
    mw[32] = word_t'(1000);
    save_words();
    predict(4, 0, 0, 0);
    chk("single_y", Data_out, word_t'(4000));
    train(5);
    mw[0]  = word_t'(1003);
    mw[32] = word_t'(1003);
    readback("single_update");

    // Randomized predict/train against the reference model
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < N_WT; k++) mw[k] = word_t'(int'($urandom_range(4000)) - 2000);
      save_words();
      predict(int'($urandom_range(120)) - 60, int'($urandom_range(120)) - 60,
              int'($urandom_range(120)) - 60, int'($urandom_range(120)) - 60);
      chk($sformatf("rand%0d_y", it), Data_out, my);
      y_before = my;
      train(int'($urandom_range(300)) - 100);
      model_train(int'(Target));
      chk($sformatf("rand%0d_dout_hold", it), Data_out, y_before);
      readback($sformatf("rand%0d_weights", it));
    end

    // Reset asserted while the network is computing
    set_uniform(1000, 1000);
    save_words();
    predict(10, 20, 30, 40);
    chk("pre_rst_y", Data_out, word_t'(800000));
    Weight_Load_enable = 1'b1;
    tb_rev_ready_h     = 1'b1;
    tick();
    Reset_l = 1'b0;
    #1;
    chk("midrst_data_out", Data_out, '0);
    chk("midrst_ready", word_t'(Ready_Signal), '0);
    chk("midrst_weight_out", New_weight_out, '0);
    Weight_Load_enable = 1'b0;
    tb_rev_ready_h     = 1'b0;
    tick();
    Reset_l = 1'b1;
    tick();
    model_reset();
    readback("midrst_weights");
    predict(10, 20, 30, 40);
    chk("post_rst_y", Data_out, '0);

    // Training with no useful activation (h all zero) changes nothing
    set_uniform(1000, 1000);
    save_words();
    train(50);
    readback("no_act_train");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
